// File: rtl/dram_burst.sv
// Clocked DRAM model: byte-masked single-cycle writes and pipelined
// burst reads with back-to-back streaming and configurable read latency.
`timescale 1ns/1ps

module dram_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LATENCY = 2,
    parameter int BLEN_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    srstn,
    input  logic                    en_wr,
    input  logic [ADDR_WIDTH-1:0]   addr_wr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] be_wr,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [BLEN_WIDTH-1:0]   rd_len,
    output logic                    rd_rdy,
    output logic                    valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    last,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BLEN_WIDTH-1:0] r_len;
    logic [BLEN_WIDTH-1:0] r_cnt;

    logic [RD_LATENCY-1:0] r_pv;
    logic [RD_LATENCY-1:0] r_pl;
    logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY];

    logic w_issue;
    logic w_final;
    logic w_accept;

    assign w_issue  = (r_state == ST_BURST);
    assign w_final  = w_issue && (r_cnt == r_len);
    assign rd_rdy   = (r_state == ST_IDLE) || (r_cnt == r_len);
    assign w_accept = rd_req && rd_rdy;

    // Storage has no reset so preloaded contents survive a reset.
    always_ff @(posedge clk) begin
        if (en_wr) begin
            for (int k = 0; k < NB; k++) begin
                if (be_wr[k]) begin
                    r_mem[addr_wr][8*k +: 8] <= data_in[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= ST_BURST;
            r_addr  <= rd_addr;
            r_len   <= rd_len;
            r_cnt   <= '0;
        end else if (w_final) begin
            r_state <= ST_IDLE;
        end else if (w_issue) begin
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_cnt   <= r_cnt + BLEN_WIDTH'(1);
        end
    end

    // Stage 0 samples the array before this edge's write lands.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_pv <= '0;
            r_pl <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pl[0] <= w_final;
            r_pd[0] <= w_issue ? r_mem[r_addr] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pl[i] <= r_pl[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign valid    = r_pv[RD_LATENCY-1];
    assign last     = r_pl[RD_LATENCY-1];
    assign data_out = r_pd[RD_LATENCY-1];
    assign busy     = (r_state == ST_BURST) || (|r_pv);

endmodule

// File: tb/tb_dram_burst.sv
// Bench for dram_burst: edge-indexed burst model plus directed
// literal checks and a randomized read/write phase.
`timescale 1ns/1ps

module tb_dram_burst;

    localparam int DW    = 32;
    localparam int AW    = 18;
    localparam int LAT   = 2;
    localparam int BW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk     = 1'b0;
    logic          srstn   = 1'b1;
    logic          en_wr   = 1'b0;
    logic [AW-1:0] addr_wr = '0;
    logic [DW-1:0] data_in = '0;
    logic [3:0]    be_wr   = '0;
    logic          rd_req  = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [BW-1:0] rd_len  = '0;
    logic          rd_rdy;
    logic          valid;
    logic [DW-1:0] data_out;
    logic          last;
    logic          busy;

    always #5 clk = ~clk;

    dram_burst #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(LAT),
        .BLEN_WIDTH(BW)
    ) dut (
        .clk(clk),
        .srstn(srstn),
        .en_wr(en_wr),
        .addr_wr(addr_wr),
        .data_in(data_in),
        .be_wr(be_wr),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_len(rd_len),
        .rd_rdy(rd_rdy),
        .valid(valid),
        .data_out(data_out),
        .last(last),
        .busy(busy)
    );

    typedef struct {
        int          vis;
        logic [31:0] d;
        bit          last;
        bit          known;
    } beat_t;

    int  total = 0;
    int  bad   = 0;
    bit  chk_on = 1'b0;
    int  cyc   = 0;

    // Model: a burst accepted at edge t0 issues beats at t0+1..m_end.
    int          m_t0   = 0;
    int          m_end  = -100;
    int          m_base = 0;
    bit          m_valid = 1'b0;
    bit          m_last  = 1'b0;
    bit          m_known = 1'b0;
    bit          m_busy  = 1'b0;
    bit          m_rdy   = 1'b1;
    logic [31:0] m_data  = '0;
    logic [31:0] mm [int];
    beat_t       pq [$];

    logic [31:0] cap_d [$];
    bit          cap_l [$];
    int          cap_c [$];
    logic [31:0] exp_d [$];
    bit          exp_l [$];
    logic [31:0] lowv [32];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    initial begin : model
        int          a;
        logic [31:0] w;
        beat_t       b;
        forever begin
            @(posedge clk or negedge srstn);
            if (!srstn) begin
                pq.delete();
                m_end   = cyc - 100;
                m_valid = 1'b0;
                m_last  = 1'b0;
                m_busy  = 1'b0;
                m_rdy   = 1'b1;
            end else begin
                cyc++;
                if (cyc > m_t0 && cyc <= m_end) begin
                    a       = (m_base + (cyc - m_t0 - 1)) % DEPTH;
                    b.vis   = cyc + LAT - 1;
                    b.known = mm.exists(a);
                    b.d     = b.known ? mm[a] : 32'h0;
                    b.last  = (cyc == m_end);
                    pq.push_back(b);
                end
                if (rd_req && cyc >= m_end) begin
                    m_t0   = cyc;
                    m_base = int'(rd_addr);
                    m_end  = cyc + int'(rd_len) + 1;
                end
                if (en_wr) begin
                    a = int'(addr_wr);
                    if (be_wr == 4'hF || mm.exists(a)) begin
                        w = mm.exists(a) ? mm[a] : 32'h0;
                        for (int k = 0; k < 4; k++) begin
                            if (be_wr[k]) w[8*k +: 8] = data_in[8*k +: 8];
                        end
                        mm[a] = w;
                    end
                end
                m_valid = 1'b0;
                m_last  = 1'b0;
                m_known = 1'b0;
                m_data  = '0;
                if (pq.size() > 0 && pq[0].vis == cyc) begin
                    b       = pq.pop_front();
                    m_valid = 1'b1;
                    m_last  = b.last;
                    m_known = b.known;
                    m_data  = b.d;
                end
                m_busy = (cyc <= m_end + LAT - 1);
                m_rdy  = (cyc + 1 >= m_end);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("valid", 32'(valid), 32'(m_valid));
                check("last", 32'(last), 32'(m_last));
                if (m_valid && m_known) check("data", data_out, m_data);
                check("rd_rdy", 32'(rd_rdy), 32'(m_rdy));
                check("busy", 32'(busy), 32'(m_busy));
                if (valid) begin
                    cap_d.push_back(data_out);
                    cap_l.push_back(last);
                    cap_c.push_back(cyc);
                end
            end
        end
    end

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d,
                      input logic [3:0] be);
        nclk();
        en_wr   = 1'b1;
        addr_wr = AW'(a);
        data_in = d;
        be_wr   = be;
        nclk();
        en_wr   = 1'b0;
    endtask

    task automatic req_burst(input int a, input int len, output int t0);
        bit ok;
        ok = 1'b0;
        t0 = 0;
        nclk();
        rd_req  = 1'b1;
        rd_addr = AW'(a);
        rd_len  = BW'(len);
        for (int n = 0; n < 100 && !ok; n++) begin
            if (rd_rdy) ok = 1'b1;
            nclk();
        end
        rd_req = 1'b0;
        t0 = cyc;
        check("req_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        nclk();
        while (busy && n < 200) begin
            nclk();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic clear_cap();
        cap_d.delete();
        cap_l.delete();
        cap_c.delete();
        exp_d.delete();
        exp_l.delete();
    endtask

    task automatic add_exp(input logic [31:0] d, input bit l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    task automatic check_cap(input string nm);
        check({nm, "_count"}, 32'(cap_d.size()), 32'(exp_d.size()));
        if (cap_d.size() == exp_d.size()) begin
            for (int i = 0; i < exp_d.size(); i++) begin
                check({nm, "_data"}, cap_d[i], exp_d[i]);
                check({nm, "_last"}, 32'(cap_l[i]), 32'(exp_l[i]));
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        int n;
        int ra;

        #12 srstn = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_rdy", 32'(rd_rdy), 32'd1);
        nclk();
        nclk();
        srstn  = 1'b1;
        chk_on = 1'b1;
        repeat (5) nclk();
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rdy", 32'(rd_rdy), 32'd1);

        for (int i = 0; i < 32; i++) begin
            lowv[i] = $urandom;
            wr(i, lowv[i], 4'hF);
            wr(DEPTH - 32 + i, $urandom, 4'hF);
        end
        for (int i = 0; i < 4; i++) wr(100 + i, 32'hA0 + 32'(i), 4'hF);
        wr(200, 32'h0000_0B00, 4'hF);
        wr(6, 32'h66, 4'hF);
        wr(7, 32'h77, 4'hF);

        // Single burst followed by a held request that streams after it.
        clear_cap();
        req_burst(100, 3, t0);
        rd_req  = 1'b1;
        rd_addr = AW'(200);
        rd_len  = '0;
        check("rdy_beat0", 32'(rd_rdy), 32'd0);
        nclk();
        check("rdy_beat1", 32'(rd_rdy), 32'd0);
        nclk();
        check("rdy_beat2", 32'(rd_rdy), 32'd0);
        nclk();
        check("rdy_final", 32'(rd_rdy), 32'd1);
        nclk();
        rd_req = 1'b0;
        wait_idle();
        add_exp(32'hA0, 1'b0);
        add_exp(32'hA1, 1'b0);
        add_exp(32'hA2, 1'b0);
        add_exp(32'hA3, 1'b1);
        add_exp(32'hB00, 1'b1);
        check_cap("b2b");
        if (cap_c.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("b2b_cycle", 32'(cap_c[i]), 32'(t0 + 2 + i));
            end
        end

        wr(DEPTH - 1, 32'hFFFF_FFFF, 4'hF);
        wr(DEPTH - 1, 32'h1122_3344, 4'b0101);
        wr(0, 32'hCAFE_0000, 4'hF);
        clear_cap();
        req_burst(DEPTH - 1, 1, t0);
        wait_idle();
        add_exp(32'hFF22_FF44, 1'b0);
        add_exp(32'hCAFE_0000, 1'b1);
        check_cap("wrap");

        // Write lands on the same edge beat 0 at addr 7 issues.
        clear_cap();
        req_burst(7, 0, t0);
        en_wr   = 1'b1;
        addr_wr = AW'(7);
        data_in = 32'h55;
        be_wr   = 4'hF;
        rd_req  = 1'b1;
        rd_addr = AW'(6);
        rd_len  = BW'(1);
        nclk();
        en_wr  = 1'b0;
        rd_req = 1'b0;
        wait_idle();
        add_exp(32'h77, 1'b1);
        add_exp(32'h66, 1'b0);
        add_exp(32'h55, 1'b1);
        check_cap("collide");

        clear_cap();
        req_burst(0, 15, t0);
        n = 0;
        while (cap_d.size() < 3 && n < 50) begin
            nclk();
            n++;
        end
        check("pre_rst_beats", 32'(cap_d.size()), 32'd3);
        srstn = 1'b0;
        #1;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rdy", 32'(rd_rdy), 32'd1);
        nclk();
        nclk();
        srstn = 1'b1;
        repeat (20) nclk();
        check("post_rst_beats", 32'(cap_d.size()), 32'd3);
        check("post_rst_busy", 32'(busy), 32'd0);
        clear_cap();
        req_burst(20, 2, t0);
        wait_idle();
        add_exp(lowv[20], 1'b0);
        add_exp(lowv[21], 1'b0);
        add_exp(lowv[22], 1'b1);
        check_cap("after_rst");

        for (int i = 0; i < 400; i++) begin
            nclk();
            ra = ($urandom % 2 == 0) ? int'($urandom % 32)
                                     : DEPTH - 32 + int'($urandom % 32);
            en_wr   = ($urandom % 3 == 0);
            addr_wr = AW'(ra);
            data_in = $urandom;
            be_wr   = 4'($urandom);
            ra = ($urandom % 2 == 0) ? int'($urandom % 17)
                                     : DEPTH - 16 + int'($urandom % 16);
            rd_req  = ($urandom % 3 == 0);
            rd_addr = AW'(ra);
            rd_len  = BW'($urandom % 16);
        end
        nclk();
        en_wr  = 1'b0;
        rd_req = 1'b0;
        wait_idle();
        repeat (3) nclk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_burst.md
# dram_burst

Parametrised, clocked DRAM model for the LeNet accelerator testbenches, replacing the fixed single-word-read model. It provides a single-cycle byte-masked write port and a burst read port with configurable pipelined read latency. Requests use a ready/request handshake, and back-to-back bursts stream without gaps. It sits between `lenet` and the bench; the bench preloads the memory array through hierarchical tasks, which are outside the scope of this spec.

## Interface
- `DATA_WIDTH`, 32, word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 18, word address width; depth is 2^ADDR_WIDTH words.
- `RD_LATENCY`, 2, cycles from beat issue to data valid; must be ≥1.
- `BLEN_WIDTH`, 4, burst length field width; a burst is `rd_len`+1 beats, up to 2^BLEN_WIDTH.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `srstn` in 1: reset; asynchronous, active-low.
- `en_wr` in 1: write strobe.
- `addr_wr` in ADDR_WIDTH: write word address.
- `data_in` in DATA_WIDTH: write data.
- `be_wr` in DATA_WIDTH/8: byte enables; bit k covers bits 8k+7:8k.
- `rd_req` in 1: read request.
- `rd_addr` in ADDR_WIDTH: burst start address.
- `rd_len` in BLEN_WIDTH: beats minus one.
- `rd_rdy` out 1: request can be accepted this cycle.
- `valid` out 1: `data_out` holds a read beat.
- `data_out` out DATA_WIDTH: read data.
- `last` out 1: qualifies the final beat of a burst.
- `busy` out 1: burst issuing or beats in flight.

## Operation
- **Write:**
  - When `en_wr` is high, each enabled byte of `mem[addr_wr]` is updated at the edge.
  - Writes are accepted in every state and are independent of reads.
- **FSM states:** IDLE and BURST.
  - IDLE: `rd_rdy`=1. `rd_req` at an edge latches `rd_addr` and `rd_len`, clears the beat counter and moves to BURST.
  - BURST: issues one beat per edge. It reads `mem[cur_addr]` into pipeline stage 1, tags the beat with `last` = (count==len), increments the address and increments the count.
  - `rd_rdy`=1 during the cycle in which the final beat is issued. A request accepted at that edge starts a new burst (stays in BURST, count cleared), so the next burst has zero bubble. Otherwise the FSM returns to IDLE.
  - `rd_req` while `rd_rdy`=0 is ignored and not queued.
- **Address arithmetic:** `cur_addr` increments modulo 2^ADDR_WIDTH, so 2^ADDR_WIDTH−1 wraps to 0.
- **Read pipeline:** RD_LATENCY register stages, each carrying {valid, last, data}. The final stage drives `valid`, `last` and `data_out`. `last` is 0 whenever `valid` is 0.
- **Write/read collision:** when a write and a beat issue hit the same address at the same edge, the beat returns the old data (read-before-write). A beat issued at any later edge returns the new data.
- **busy:** equals (state==BURST) OR (any pipeline stage valid).
- **Reset:**
  - State goes to IDLE. All pipeline valid/last bits, `data_out`, `valid`, `last` and `busy` go to 0. `rd_rdy` goes to 1.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst; no beats of it appear after reset is released.

## Timing
- Request accepted at edge T0 with N = `rd_len`+1:
  - Beat i (0…N−1) is issued at edge T0+1+i.
  - Beat i is visible with `valid`=1 after edge T0+i+RD_LATENCY.
  - With RD_LATENCY=1, the first beat appears one cycle after acceptance.
- `valid` is high for exactly N consecutive cycles per burst.
- Back-to-back bursts produce a continuous `valid` stream. `last` marks each burst's final beat.
- `rd_rdy` is a combinational function of state and count only. It never depends on `rd_req`.
- `busy` falls after the edge at which the last beat leaves the final pipeline stage.

## Test plan
- **Reset values:** assert `srstn`=0 asynchronously mid-cycle → immediately `valid`=0, `last`=0, `busy`=0, `data_out`=0, `rd_rdy`=1. Release, then idle 5 cycles → outputs unchanged.
- **Single burst:** preload mem[100..103]=0xA0..0xA3, RD_LATENCY=2, request `rd_addr`=100, `rd_len`=3 accepted at T0 → `valid` high after edges T0+2..T0+5 with data 0xA0..0xA3; `last` only with 0xA3; `rd_rdy`=0 in cycles T0+1..T0+3.
- **Back-to-back:** second request (`rd_addr`=200, `rd_len`=0) held high until accepted → accepted at edge T0+4. Then 5 contiguous valid beats, `last` asserted on 0xA3 and on mem[200].
- **Wrap and bytes:**
  - Write 0x11223344 with `be_wr`=4'b0101 over 0xFFFFFFFF at 2^18−1 → word reads 0xFF22FF44.
  - Burst `rd_addr`=2^18−1, `rd_len`=1 → beats mem[262143] then mem[0].
- **Collision:** write 0x55 to addr 7 at the same edge beat 0 of a burst at 7 issues → beat returns the old value. A 2-beat burst at 6 requested one cycle later returns 0x55 for addr 7.
- **Reset mid-burst:** `rd_len`=15, assert reset after 3 beats are visible, release, wait 20 cycles → no further `valid`; `busy`=0; a new request then completes normally.
